// File: rtl/arb2_pkg.sv
// Shared types and sizing for the two-input round-robin stream arbiter.
// Optional per-input transfer counters are enabled by defining ARB2_STATS_EN.
package arb2_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int CNT_W     = 16;

    // Identifies a producer; also records which producer won most recently.
    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_e;

endpackage

// File: rtl/stream_arb2_if.sv
// Handshake bundle between the two producers, the arbiter and the consumer.
// The slave modport is the arbiter's view; master is the environment's view.
interface stream_arb2_if import arb2_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    src_e             out_src;
    logic             out_ready;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_src
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a contested cycle goes to whichever input did not win last.
module rr_pick2 import arb2_pkg::*; (
    input  logic v0,
    input  logic v1,
    input  src_e last,
    output logic gnt_valid,
    output src_e gnt
);

    assign gnt_valid = v0 || v1;

    always_comb begin
        gnt = SRC0;
        if (v0 && v1) begin
            gnt = (last == SRC0) ? SRC1 : SRC0;
        end else if (v1) begin
            gnt = SRC1;
        end
    end

endmodule

// File: rtl/stream_arb2.sv
// Two-input round-robin stream arbiter feeding a single registered output slot.
// Define ARB2_STATS_EN to add saturating per-input transfer counters cnt0/cnt1.
module stream_arb2 import arb2_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    stream_arb2_if.slave         bus
`ifdef ARB2_STATS_EN
    ,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1
`endif
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    src_e             out_src_q,   out_src_d;
    src_e             last_q,      last_d;

    logic             gnt_valid;
    src_e             gnt;
    logic             free;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    rr_pick2 u_pick (
        .v0        (bus.in0_valid),
        .v1        (bus.in1_valid),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    // A full slot being drained this cycle can take a new item in the same cycle.
    assign free     = !out_valid_q || bus.out_ready;
    assign xfer     = reset_n && free && gnt_valid;
    assign sel_data = (gnt == SRC1) ? bus.in1_data : bus.in0_data;

    assign bus.in0_ready = xfer && (gnt == SRC0);
    assign bus.in1_ready = xfer && (gnt == SRC1);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_src_d   = gnt;
            last_d      = gnt;
        end else if (free && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC0;
            last_q      <= SRC1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
        end
    end

`ifdef ARB2_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (bus.in0_ready && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_ONE;
        if (bus.in1_ready && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_stream_arb2.sv
// Self-checking bench for stream_arb2: a slot-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_stream_arb2;
    import arb2_pkg::*;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    stream_arb2_if #(.WIDTH(4)) bus ();

`ifdef ARB2_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    stream_arb2 #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef ARB2_STATS_EN
        ,
        .cnt0    (cnt0),
        .cnt1    (cnt1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the output slot as a held item, the last winner, and transfer totals.
    bit       m_valid;
    bit [3:0] m_data;
    bit       m_src;
    bit       m_last;
    int       m_cnt [2];

    task automatic model_reset();
        m_valid  = 1'b0;
        m_data   = 4'h0;
        m_src    = 1'b0;
        m_last   = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    // Winning producer for the current inputs, or -1 when nobody is asking.
    function automatic int winner();
        if (bus.in0_valid && bus.in1_valid) return m_last ? 0 : 1;
        if (bus.in0_valid) return 0;
        if (bus.in1_valid) return 1;
        return -1;
    endfunction

    function automatic bit slot_free();
        return !m_valid || bus.out_ready;
    endfunction

    function automatic bit exp_ready(input int n);
        return reset_n && slot_free() && (winner() == n);
    endfunction

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    // Model advance on each rising edge, from the inputs held across that edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                model_reset();
            end else begin
                automatic int w = winner();
                if (w >= 0 && slot_free()) begin
                    m_valid = 1'b1;
                    m_data  = (w == 1) ? bus.in1_data : bus.in0_data;
                    m_src   = w[0];
                    m_last  = w[0];
                    m_cnt[w]++;
                end else if (bus.out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Compare DUT against the model mid-cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            check("mdl_out_valid", bus.out_valid, m_valid);
            check("mdl_out_data",  bus.out_data,  m_data);
            check("mdl_out_src",   bus.out_src,   m_src);
            check("mdl_in0_ready", bus.in0_ready, exp_ready(0));
            check("mdl_in1_ready", bus.in1_ready, exp_ready(1));
`ifdef ARB2_STATS_EN
            check("mdl_cnt0", cnt0, sat16(m_cnt[0]));
            check("mdl_cnt1", cnt1, sat16(m_cnt[1]));
`endif
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n       = 1'b0;
        bus.in0_valid = 1'b1;
        bus.in0_data  = 4'h3;
        bus.in1_valid = 1'b1;
        bus.in1_data  = 4'hC;
        bus.out_ready = 1'b1;

        // 1: reset holds everything at zero even with both producers asking.
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data",  bus.out_data,  4'h0);
        check("rst_in0_ready", bus.in0_ready, 1'b0);
        check("rst_in1_ready", bus.in1_ready, 1'b0);
        #1 reset_n = 1'b1;
        #1;
        check("rel_in0_ready", bus.in0_ready, 1'b1);
        check("rel_in1_ready", bus.in1_ready, 1'b0);

        // 2: contested stream alternates 0,1,0,1,0,1.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("alt_out_valid", bus.out_valid, 1'b1);
            check("alt_out_src",   bus.out_src,   (i % 2 == 0) ? 1'b0 : 1'b1);
            check("alt_out_data",  bus.out_data,  (i % 2 == 0) ? 4'h3 : 4'hC);
        end

        // 3: stall holds item C from source 1; release drains and refills at once.
        bus.out_ready = 1'b0;
        #1;
        check("stall_in0_ready", bus.in0_ready, 1'b0);
        check("stall_in1_ready", bus.in1_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_out_data",  bus.out_data,  4'hC);
            check("stall_out_src",   bus.out_src,   1'b1);
            check("stall_out_valid", bus.out_valid, 1'b1);
            check("stall_rdy",       {bus.in0_ready, bus.in1_ready}, 2'b00);
        end
        bus.out_ready = 1'b1;
        #1;
        check("drain_in0_ready", bus.in0_ready, 1'b1);
        check("drain_in1_ready", bus.in1_ready, 1'b0);
        @(posedge clk); #1;
        check("drain_out_data", bus.out_data, 4'h3);
        check("drain_out_src",  bus.out_src,  1'b0);

        // 4: only producer 1 asking; afterwards a contested cycle goes to 0.
        bus.in0_valid = 1'b0;
        bus.in1_data  = 4'h9;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("solo_in1_ready", bus.in1_ready, 1'b1);
            @(posedge clk); #1;
            check("solo_out_data", bus.out_data, 4'h9);
            check("solo_out_src",  bus.out_src,  1'b1);
        end
        bus.in0_valid = 1'b1;
        bus.in0_data  = 4'h5;
        #1;
        check("recont_in0_ready", bus.in0_ready, 1'b1);
        check("recont_in1_ready", bus.in1_ready, 1'b0);
        @(posedge clk); #1;
        check("recont_out_data",  bus.out_data,  4'h5);
        check("recont_out_src",   bus.out_src,   1'b0);
        check("recont_out_valid", bus.out_valid, 1'b1);

        // 5: reset mid-cycle empties the slot without waiting for an edge.
        #2 reset_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_out_data",  bus.out_data,  4'h0);
        check("arst_in0_ready", bus.in0_ready, 1'b0);
`ifdef ARB2_STATS_EN
        check("arst_cnt0", cnt0, 16'h0000);
        check("arst_cnt1", cnt1, 16'h0000);
`endif
        bus.in1_valid = 1'b0;
        @(negedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_out_data", bus.out_data, 4'h5);
        check("post_out_src",  bus.out_src,  1'b0);

`ifdef ARB2_STATS_EN
        // 6: producer 0 alone for 70000 edges pushes cnt0 into saturation.
        repeat (70000) @(posedge clk);
        #1;
        check("sat_cnt0", cnt0, 16'hFFFF);
        check("sat_cnt1", cnt1, 16'h0000);
`endif

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
